// File: rtl/lcd_nibble_writer.sv
// -----------------------------------------------------------------------------
// lcd_nibble_writer
//
// Drives the HD44780 character LCD 4-bit bus (SF_D[11:8], LCD_E, LCD_RS,
// LCD_RW) on behalf of the instruction datapath. One accepted request sends
// either a full byte (upper nibble first, then lower) or only the upper
// nibble (used during controller init). Each write ends with a post-write
// wait so the controller can finish the command before the next request.
//
// Ports:
//   Clock        - system clock (50 MHz board clock assumed for timing params)
//   Reset        - asynchronous, active-high
//   iWrite       - request strobe, sampled only while idle
//   iData[7:0]   - byte to send, upper nibble goes first
//   iRS          - 0 = command register, 1 = data register
//   iNibbleOnly  - 1 = send only iData[7:4]
//   iLongWait    - 1 = use T_LONG instead of T_POST as post-write wait
//   oBusy        - request in progress
//   oDone        - one-cycle completion pulse (first idle cycle)
//   oLCD_E       - LCD enable
//   oLCD_RS      - LCD register select
//   oLCD_RW      - LCD read/write, tied low (write only)
//   oLCD_Data    - LCD data nibble
//
// Every output except the constant oLCD_RW is a flop, so the pins never see
// a combinational path from the request inputs.
// -----------------------------------------------------------------------------
module lcd_nibble_writer #(
    parameter int T_SU   = 2,      // data/RS setup cycles before E rises
    parameter int T_E    = 12,     // E high cycles
    parameter int T_H    = 1,      // data hold cycles after E falls
    parameter int T_GAP  = 50,     // cycles between upper and lower nibble
    parameter int T_POST = 2000,   // normal post-write wait
    parameter int T_LONG = 82000,  // post-write wait for clear/home
    parameter int CW     = 20      // counter width, holds max(T_LONG,T_GAP)-1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iWrite,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iNibbleOnly,
    input  logic       iLongWait,
    output logic       oBusy,
    output logic       oDone,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic [3:0] oLCD_Data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_GAP,
        S_WAIT
    } state_t;

    // A state loaded with N-1 is left when the counter reads 0, so it
    // lasts exactly N cycles.
    localparam logic [CW-1:0] LD_SU   = CW'(T_SU - 1);
    localparam logic [CW-1:0] LD_E    = CW'(T_E - 1);
    localparam logic [CW-1:0] LD_H    = CW'(T_H - 1);
    localparam logic [CW-1:0] LD_GAP  = CW'(T_GAP - 1);
    localparam logic [CW-1:0] LD_POST = CW'(T_POST - 1);
    localparam logic [CW-1:0] LD_LONG = CW'(T_LONG - 1);

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            second, second_d;      // lower nibble in flight
    logic [3:0]      lo_nib, lo_nib_d;      // latched iData[3:0]
    logic            nib_only, nib_only_d;  // latched iNibbleOnly
    logic            long_wait, long_wait_d;// latched iLongWait
    logic [3:0]      data_d;
    logic            rs_d;
    logic            done_d;
    logic            cnt_zero;

    assign cnt_zero = (cnt == '0);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state;
        cnt_d       = cnt;
        second_d    = second;
        lo_nib_d    = lo_nib;
        nib_only_d  = nib_only;
        long_wait_d = long_wait;
        data_d      = oLCD_Data;
        rs_d        = oLCD_RS;
        done_d      = 1'b0;

        case (state)
            S_IDLE: begin
                if (iWrite) begin
                    state_d     = S_SETUP;
                    cnt_d       = LD_SU;
                    second_d    = 1'b0;
                    lo_nib_d    = iData[3:0];
                    nib_only_d  = iNibbleOnly;
                    long_wait_d = iLongWait;
                    // Upper nibble and RS go to the pins on the accepting
                    // edge so setup time starts counting immediately.
                    data_d      = iData[7:4];
                    rs_d        = iRS;
                end
            end

            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_PULSE;
                    cnt_d   = LD_E;
                end else begin
                    cnt_d   = cnt - 1'b1;
                end
            end

            S_PULSE: begin
                if (cnt_zero) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_H;
                end else begin
                    cnt_d   = cnt - 1'b1;
                end
            end

            S_HOLD: begin
                if (cnt_zero) begin
                    if (!nib_only && !second) begin
                        state_d = S_GAP;
                        cnt_d   = LD_GAP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = long_wait ? LD_LONG : LD_POST;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end

            S_GAP: begin
                if (cnt_zero) begin
                    state_d  = S_SETUP;
                    cnt_d    = LD_SU;
                    second_d = 1'b1;
                    data_d   = lo_nib;
                end else begin
                    cnt_d    = cnt - 1'b1;
                end
            end

            S_WAIT: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            second    <= 1'b0;
            lo_nib    <= 4'h0;
            nib_only  <= 1'b0;
            long_wait <= 1'b0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oLCD_E    <= 1'b0;
            oLCD_RS   <= 1'b0;
            oLCD_Data <= 4'h0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // values from before this edge, regardless of statement order.
            state     <= state_d;
            cnt       <= cnt_d;
            second    <= second_d;
            lo_nib    <= lo_nib_d;
            nib_only  <= nib_only_d;
            long_wait <= long_wait_d;
            // Busy and E are decoded from the next state so they line up
            // with the state they describe instead of lagging by a cycle.
            oBusy     <= (state_d != S_IDLE);
            oLCD_E    <= (state_d == S_PULSE);
            oDone     <= done_d;
            oLCD_RS   <= rs_d;
            oLCD_Data <= data_d;
        end
    end

    assign oLCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// -----------------------------------------------------------------------------
// tb_lcd_nibble_writer
//
// Directed bench for lcd_nibble_writer. T_LONG is shortened to 8200 so the
// long-wait case stays short; all other timing parameters are the defaults.
// Cycle 0 is the first cycle with oBusy=1. Expected values (defaults):
//   byte mode   : E high 2..13 and 67..78, busy 2*15+50+2000 = 2080 cycles
//   nibble mode : E high 2..13, busy 15+2000 = 2015 cycles
//   long, byte  : busy 2*15+50+8200 = 8280 cycles
// -----------------------------------------------------------------------------
module tb_lcd_nibble_writer;

    localparam int T_SU   = 2;
    localparam int T_E    = 12;
    localparam int T_H    = 1;
    localparam int T_GAP  = 50;
    localparam int T_POST = 2000;
    localparam int T_LONG = 8200;
    localparam int LIMIT  = 20000;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iWrite = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iRS = 1'b0;
    logic       iNibbleOnly = 1'b0;
    logic       iLongWait = 1'b0;
    logic       oBusy, oDone, oLCD_E, oLCD_RS, oLCD_RW;
    logic [3:0] oLCD_Data;

    int tests = 0;
    int fails = 0;

    // Per-transfer observations filled in by collect()
    int         pcnt;
    int         rise [2];
    int         fall [2];
    int         nib  [2];
    int         busy_cyc;
    int         done_cyc;
    int         rs_bad;
    logic [3:0] hist [0:127];

    lcd_nibble_writer #(
        .T_SU  (T_SU),
        .T_E   (T_E),
        .T_H   (T_H),
        .T_GAP (T_GAP),
        .T_POST(T_POST),
        .T_LONG(T_LONG),
        .CW    (20)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iWrite     (iWrite),
        .iData      (iData),
        .iRS        (iRS),
        .iNibbleOnly(iNibbleOnly),
        .iLongWait  (iLongWait),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oLCD_E     (oLCD_E),
        .oLCD_RS    (oLCD_RS),
        .oLCD_RW    (oLCD_RW),
        .oLCD_Data  (oLCD_Data)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Present a request for one edge, then scramble the inputs so any
    // late sampling of them would show up on the bus.
    task automatic accept(input logic [7:0] d, input logic rs,
                          input logic nib_only, input logic lw);
        iData       = d;
        iRS         = rs;
        iNibbleOnly = nib_only;
        iLongWait   = lw;
        iWrite      = 1'b1;
        @(posedge Clock);
        #1;
        iWrite      = 1'b0;
        iData       = ~d;
        iRS         = ~rs;
        iNibbleOnly = ~nib_only;
        iLongWait   = ~lw;
    endtask

    // Observe one transfer from cycle 0 (current sample point) until the
    // first idle cycle. inject >= 0 pulses a stray 8'hFF request then.
    task automatic collect(input int inject, input logic exp_rs);
        logic prev_e = 1'b0;
        int   cyc    = 0;
        pcnt     = 0;
        rise     = '{-1, -1};
        fall     = '{-1, -1};
        nib      = '{-1, -1};
        busy_cyc = 0;
        done_cyc = -1;
        rs_bad   = 0;
        while (cyc < LIMIT) begin
            if (cyc == inject) begin
                iWrite      = 1'b1;
                iData       = 8'hFF;
                iRS         = ~exp_rs;
                iNibbleOnly = 1'b1;
            end else if (cyc == inject + 1) begin
                iWrite = 1'b0;
            end
            if (cyc < 128) hist[cyc] = oLCD_Data;
            if (!oBusy) begin
                done_cyc = oDone ? cyc : -2;
                break;
            end
            busy_cyc++;
            if (oLCD_RS !== exp_rs) rs_bad++;
            if (oLCD_E && !prev_e) begin
                if (pcnt < 2) begin
                    rise[pcnt] = cyc;
                    nib[pcnt]  = int'(oLCD_Data);
                end
                pcnt++;
            end
            if (!oLCD_E && prev_e && pcnt <= 2) fall[pcnt-1] = cyc - 1;
            prev_e = oLCD_E;
            @(posedge Clock);
            #1;
            cyc++;
        end
        if (cyc >= LIMIT) check("timeout", 1, 0);
    endtask

    // Data must equal the pulse's nibble from T_SU before E rises through
    // T_H after E falls.
    task automatic check_stable(input string tag);
        int bad = 0;
        for (int k = 0; k < 2 && k < pcnt; k++)
            for (int c = rise[k] - T_SU; c <= fall[k] + T_H; c++)
                if (c >= 0 && c < 128 && int'(hist[c]) != nib[k]) bad++;
        check(tag, bad, 0);
    endtask

    // One cycle after the done cycle: pulse over, bus holds last values.
    task automatic post_idle(input string tag, input int exp_nib, input logic exp_rs);
        @(posedge Clock);
        #1;
        check({tag, "_done_once"}, int'(oDone), 0);
        check({tag, "_hold_data"}, int'(oLCD_Data), exp_nib);
        check({tag, "_hold_rs"}, int'(oLCD_RS), int'(exp_rs));
    endtask

    initial begin
        int nd, nb;

        // ---------------- reset ----------------
        repeat (2) @(posedge Clock);
        #1;
        check("rst_busy", int'(oBusy), 0);
        check("rst_done", int'(oDone), 0);
        check("rst_e", int'(oLCD_E), 0);
        check("rst_rs", int'(oLCD_RS), 0);
        check("rst_rw", int'(oLCD_RW), 0);
        check("rst_data", int'(oLCD_Data), 0);
        @(negedge Clock);
        Reset = 1'b0;

        // ---------------- byte write 8'h48, data register ----------------
        @(negedge Clock);
        accept(8'h48, 1'b1, 1'b0, 1'b0);
        collect(-1, 1'b1);
        check("byte_pulses", pcnt, 2);
        check("byte_rise0", rise[0], 2);
        check("byte_fall0", fall[0], 13);
        check("byte_nib0", nib[0], 4);
        check("byte_rise1", rise[1], 67);
        check("byte_fall1", fall[1], 78);
        check("byte_nib1", nib[1], 8);
        check("byte_rs", rs_bad, 0);
        check("byte_busy", busy_cyc, 2080);
        check("byte_done", done_cyc, 2080);
        check_stable("byte_stable");
        post_idle("byte", 8, 1'b1);

        // ---------------- nibble init 8'h30 ----------------
        @(negedge Clock);
        accept(8'h30, 1'b0, 1'b1, 1'b0);
        collect(-1, 1'b0);
        check("nib_pulses", pcnt, 1);
        check("nib_rise0", rise[0], 2);
        check("nib_fall0", fall[0], 13);
        check("nib_nib0", nib[0], 3);
        check("nib_rs", rs_bad, 0);
        check("nib_busy", busy_cyc, 2015);
        check("nib_done", done_cyc, 2015);
        check_stable("nib_stable");
        post_idle("nib", 3, 1'b0);

        // ---------------- long wait 8'h01 ----------------
        @(negedge Clock);
        accept(8'h01, 1'b0, 1'b0, 1'b1);
        collect(-1, 1'b0);
        check("long_pulses", pcnt, 2);
        check("long_nib0", nib[0], 0);
        check("long_nib1", nib[1], 1);
        check("long_done", done_cyc, 8280);
        post_idle("long", 1, 1'b0);

        // ---------------- ignored request during PULSE ----------------
        @(negedge Clock);
        accept(8'h28, 1'b0, 1'b0, 1'b0);
        collect(5, 1'b0);
        check("ign_pulses", pcnt, 2);
        check("ign_nib0", nib[0], 2);
        check("ign_nib1", nib[1], 8);
        check("ign_rs", rs_bad, 0);
        check("ign_done", done_cyc, 2080);
        check_stable("ign_stable");
        post_idle("ign", 8, 1'b0);

        // ---------------- reset mid-WAIT ----------------
        @(negedge Clock);
        accept(8'h5A, 1'b1, 1'b0, 1'b0);
        repeat (300) @(posedge Clock);
        #3;
        Reset = 1'b1;
        #1;  // still 6 time units before the next rising edge
        check("mid_rst_busy", int'(oBusy), 0);
        check("mid_rst_done", int'(oDone), 0);
        check("mid_rst_e", int'(oLCD_E), 0);
        check("mid_rst_rs", int'(oLCD_RS), 0);
        check("mid_rst_data", int'(oLCD_Data), 0);
        @(negedge Clock);
        Reset = 1'b0;
        nd = 0;
        nb = 0;
        repeat (2100) begin
            @(posedge Clock);
            #1;
            if (oDone) nd++;
            if (oBusy) nb++;
        end
        check("abort_no_done", nd, 0);
        check("abort_no_busy", nb, 0);

        // ---------------- back-to-back ----------------
        @(negedge Clock);
        accept(8'h30, 1'b0, 1'b1, 1'b0);
        collect(-1, 1'b0);
        check("b2b_first_done", done_cyc, 2015);
        // Still inside the oDone cycle: the next request must be taken.
        accept(8'h48, 1'b1, 1'b0, 1'b0);
        check("b2b_busy", int'(oBusy), 1);
        check("b2b_data", int'(oLCD_Data), 4);
        check("b2b_rs", int'(oLCD_RS), 1);
        collect(-1, 1'b1);
        check("b2b_pulses", pcnt, 2);
        check("b2b_nib1", nib[1], 8);
        check("b2b_done", done_cyc, 2080);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
